// File: rtl/csr_file_timer.sv
// LoongArch CSR file for the WB exception path.
// Adds BADV, TID, a countdown timer and interrupt-pending detection.
module csr_file_timer #(
  parameter int          SAVE_NUM = 4,
  parameter int          TIMER_W  = 32,
  parameter logic [31:0] TID_RST  = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] era_out,
  output logic        has_int
);

  localparam logic [13:0] A_CRMD   = 14'h00;
  localparam logic [13:0] A_PRMD   = 14'h01;
  localparam logic [13:0] A_ECFG   = 14'h04;
  localparam logic [13:0] A_ESTAT  = 14'h05;
  localparam logic [13:0] A_ERA    = 14'h06;
  localparam logic [13:0] A_BADV   = 14'h07;
  localparam logic [13:0] A_EENTRY = 14'h0C;
  localparam logic [13:0] A_SAVE0  = 14'h30;
  localparam logic [13:0] A_TID    = 14'h40;
  localparam logic [13:0] A_TCFG   = 14'h41;
  localparam logic [13:0] A_TVAL   = 14'h42;
  localparam logic [13:0] A_TICLR  = 14'h44;

  logic [8:0]         crmd;
  logic [2:0]         prmd;
  logic [12:0]        lie;
  logic [1:0]         is_sw;
  logic [7:0]         is_hw;
  logic               is_ipi;
  logic               is_tmr;
  logic [5:0]         ecode;
  logic [8:0]         esub;
  logic [31:0]        era;
  logic [31:0]        badv;
  logic [25:0]        eentry;
  logic [31:0]        save [SAVE_NUM];
  logic [31:0]        tid;
  logic [TIMER_W-1:0] tcfg;
  logic [TIMER_W-1:0] tval;

  logic [31:0] estat;
  logic [31:0] save_rd;
  logic [31:0] rd_raw;
  logic [31:0] wnew;
  logic        wr;
  logic        tcfg_wr;
  logic        fire;
  logic        ticlr;

  assign estat = {1'b0, esub, ecode, 3'b0, is_ipi, is_tmr,
                  1'b0, is_hw, is_sw};

  always_comb begin
    save_rd = '0;
    for (int k = 0; k < SAVE_NUM; k++)
      if (csr_num == A_SAVE0 + 14'(k))
        save_rd = save[k];
  end

  always_comb begin
    rd_raw = '0;
    unique case (1'b1)
      (csr_num == A_CRMD):   rd_raw = {23'b0, crmd};
      (csr_num == A_PRMD):   rd_raw = {29'b0, prmd};
      (csr_num == A_ECFG):   rd_raw = {19'b0, lie};
      (csr_num == A_ESTAT):  rd_raw = estat;
      (csr_num == A_ERA):    rd_raw = era;
      (csr_num == A_BADV):   rd_raw = badv;
      (csr_num == A_EENTRY): rd_raw = {eentry, 6'b0};
      (csr_num == A_TID):    rd_raw = tid;
      (csr_num == A_TCFG):   rd_raw = 32'(tcfg);
      (csr_num == A_TVAL):   rd_raw = 32'(tval);
      default:               rd_raw = save_rd;
    endcase
  end

  assign csr_rvalue = csr_re ? rd_raw : 32'h0;
  assign wnew = (csr_wmask & csr_wvalue) | (~csr_wmask & rd_raw);
  assign wr = csr_we & ~wb_ex;

  assign tcfg_wr = wr && (csr_num == A_TCFG);
  assign fire = tcfg[0] && (tval == '0);
  assign ticlr = wr && (csr_num == A_TICLR)
                 && csr_wmask[0] && csr_wvalue[0];

  assign ex_entry = {eentry, 6'b0};
  assign era_out = era;
  assign has_int = crmd[2] & |(estat[12:0] & lie);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd <= 9'h008;
      prmd <= '0;
    end else if (wb_ex) begin
      prmd <= crmd[2:0];
      crmd[2:0] <= 3'b000;
    end else begin
      // ERTN owns CRMD this cycle; PRMD stays writable
      if (ertn_flush)
        crmd[2:0] <= prmd;
      else if (wr && csr_num == A_CRMD)
        crmd <= wnew[8:0];
      if (wr && csr_num == A_PRMD)
        prmd <= wnew[2:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lie    <= '0;
      is_sw  <= '0;
      is_hw  <= '0;
      is_ipi <= 1'b0;
      ecode  <= '0;
      esub   <= '0;
      era    <= '0;
      badv   <= '0;
      eentry <= '0;
      tid    <= TID_RST;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
      if (wb_ex) begin
        ecode <= wb_ecode;
        esub  <= wb_esubcode;
        era   <= wb_pc;
        if (wb_ecode == 6'h08)
          badv <= wb_pc;
        else if (wb_ecode == 6'h09)
          badv <= wb_vaddr;
      end else if (wr) begin
        unique case (1'b1)
          (csr_num == A_ECFG):   lie <= wnew[12:0] & 13'h1BFF;
          (csr_num == A_ESTAT):  is_sw <= wnew[1:0];
          (csr_num == A_ERA):    era <= wnew;
          (csr_num == A_BADV):   badv <= wnew;
          (csr_num == A_EENTRY): eentry <= wnew[31:6];
          (csr_num == A_TID):    tid <= wnew;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < SAVE_NUM; k++)
        save[k] <= '0;
    end else begin
      for (int k = 0; k < SAVE_NUM; k++)
        if (wr && csr_num == A_SAVE0 + 14'(k))
          save[k] <= wnew;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg   <= '0;
      tval   <= '1;
      is_tmr <= 1'b0;
    end else begin
      if (tcfg_wr) begin
        tcfg <= wnew[TIMER_W-1:0];
        tval <= {wnew[TIMER_W-1:2], 2'b00};
      end else if (fire) begin
        tval <= tcfg[1] ? {tcfg[TIMER_W-1:2], 2'b00} : '1;
      end else if (tcfg[0] && !(&tval)) begin
        tval <= tval - 1'b1;
      end
      // a fire in the same cycle as TICLR keeps the flag set
      if (fire)
        is_tmr <= 1'b1;
      else if (ticlr)
        is_tmr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csr_file_timer.sv
// Bench for csr_file_timer: directed scenarios plus random traffic
// checked cycle by cycle against a mask-based register model.
module tb_csr_file_timer;

  logic        clk;
  logic        resetn;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic        ertn_flush;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] era_out;
  logic        has_int;

  int checks;
  int failures;

  csr_file_timer #(
    .SAVE_NUM(2),
    .TIMER_W (32),
    .TID_RST (32'h0)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .csr_re     (csr_re),
    .csr_num    (csr_num),
    .csr_rvalue (csr_rvalue),
    .csr_we     (csr_we),
    .csr_wmask  (csr_wmask),
    .csr_wvalue (csr_wvalue),
    .wb_ex      (wb_ex),
    .ertn_flush (ertn_flush),
    .wb_pc      (wb_pc),
    .wb_vaddr   (wb_vaddr),
    .wb_ecode   (wb_ecode),
    .wb_esubcode(wb_esubcode),
    .hw_int_in  (hw_int_in),
    .ipi_int_in (ipi_int_in),
    .ex_entry   (ex_entry),
    .era_out    (era_out),
    .has_int    (has_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_crmd, m_prmd, m_lie, m_sw, m_hw, m_ipi, m_tflag;
  logic [31:0] m_ecode, m_esub, m_era, m_badv, m_eentry, m_tid;
  logic [31:0] m_tcfg, m_tval;
  logic [31:0] m_save [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mw(input logic [31:0] old);
    return (csr_wmask & csr_wvalue) | (~csr_wmask & old);
  endfunction

  function automatic logic [31:0] m_estat();
    return (m_esub << 22) | (m_ecode << 16) | (m_ipi << 12)
         | (m_tflag << 11) | (m_hw << 2) | m_sw;
  endfunction

  function automatic logic [31:0] m_read(input logic re,
                                         input logic [13:0] n);
    if (!re) return 32'h0;
    case (n)
      14'h00: return m_crmd;
      14'h01: return m_prmd;
      14'h04: return m_lie;
      14'h05: return m_estat();
      14'h06: return m_era;
      14'h07: return m_badv;
      14'h0C: return m_eentry;
      14'h30: return m_save[0];
      14'h31: return m_save[1];
      14'h40: return m_tid;
      14'h41: return m_tcfg;
      14'h42: return m_tval;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_int();
    return {31'b0, m_crmd[2] && ((m_estat() & m_lie & 32'h1FFF) != 0)};
  endfunction

  task automatic m_reset();
    m_crmd = 32'h8; m_prmd = 0; m_lie = 0; m_sw = 0; m_hw = 0;
    m_ipi = 0; m_tflag = 0; m_ecode = 0; m_esub = 0; m_era = 0;
    m_badv = 0; m_eentry = 0; m_tid = 0; m_tcfg = 0;
    m_tval = 32'hFFFF_FFFF; m_save[0] = 0; m_save[1] = 0;
  endtask

  task automatic m_tick();
    logic [31:0] o_prmd, o_tcfg, o_tval;
    logic w, fire;
    o_prmd = m_prmd; o_tcfg = m_tcfg; o_tval = m_tval;
    w = csr_we && !wb_ex;
    fire = o_tcfg[0] && (o_tval == 0);
    if (wb_ex) begin
      m_prmd = m_crmd & 32'h7;
      m_crmd = m_crmd & ~32'h7;
      m_era = wb_pc;
      m_ecode = {26'b0, wb_ecode};
      m_esub = {23'b0, wb_esubcode};
      if (wb_ecode == 6'h08) m_badv = wb_pc;
      else if (wb_ecode == 6'h09) m_badv = wb_vaddr;
    end else if (ertn_flush) begin
      m_crmd = (m_crmd & ~32'h7) | (o_prmd & 32'h7);
    end
    if (w) begin
      case (csr_num)
        14'h00: if (!ertn_flush) m_crmd = mw(m_crmd) & 32'h1FF;
        14'h01: m_prmd = mw(m_prmd) & 32'h7;
        14'h04: m_lie = mw(m_lie) & 32'h1BFF;
        14'h05: m_sw = mw(m_estat()) & 32'h3;
        14'h06: m_era = mw(m_era);
        14'h07: m_badv = mw(m_badv);
        14'h0C: m_eentry = mw(m_eentry) & 32'hFFFF_FFC0;
        14'h30: m_save[0] = mw(m_save[0]);
        14'h31: m_save[1] = mw(m_save[1]);
        14'h40: m_tid = mw(m_tid);
        default: ;
      endcase
    end
    if (w && csr_num == 14'h41) begin
      m_tcfg = mw(o_tcfg);
      m_tval = m_tcfg & ~32'h3;
    end else if (o_tcfg[0]) begin
      if (o_tval == 0)
        m_tval = o_tcfg[1] ? (o_tcfg & ~32'h3) : 32'hFFFF_FFFF;
      else if (o_tval != 32'hFFFF_FFFF)
        m_tval = o_tval - 1;
    end
    if (fire) m_tflag = 1;
    else if (w && csr_num == 14'h44 && csr_wmask[0] && csr_wvalue[0])
      m_tflag = 0;
    m_hw = {24'b0, hw_int_in};
    m_ipi = {31'b0, ipi_int_in};
  endtask

  // called just after a negedge; returns at the next negedge
  task automatic step();
    #1;
    chk("rvalue", csr_rvalue, m_read(csr_re, csr_num));
    chk("has_int", {31'b0, has_int}, m_int());
    chk("ex_entry", ex_entry, m_eentry);
    chk("era_out", era_out, m_era);
    @(posedge clk);
    if (!resetn) m_reset();
    else m_tick();
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [13:0] n,
                      input logic [31:0] exp);
    csr_re = 1'b1;
    csr_num = n;
    #1;
    chk(tag, csr_rvalue, exp);
  endtask

  task automatic wr_csr(input logic [13:0] n, input logic [31:0] m,
                        input logic [31:0] v);
    csr_we = 1'b1; csr_num = n; csr_wmask = m; csr_wvalue = v;
    step();
    csr_we = 1'b0;
  endtask

  logic [13:0] addrs [15];

  initial begin
    checks = 0; failures = 0;
    addrs = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C,
              14'h30, 14'h31, 14'h32, 14'h40, 14'h41, 14'h42, 14'h44,
              14'h3F};
    resetn = 1'b0; csr_re = 1'b1; csr_num = '0; csr_we = 1'b0;
    csr_wmask = '0; csr_wvalue = '0; wb_ex = 1'b0; ertn_flush = 1'b0;
    wb_pc = '0; wb_vaddr = '0; wb_ecode = '0; wb_esubcode = '0;
    hw_int_in = '0; ipi_int_in = 1'b0;
    m_reset();
    @(negedge clk);
    step();
    resetn = 1'b1;
    step();

    // reset while counting
    wr_csr(14'h41, 32'hFFFF_FFFF, 32'h11);
    peek("tval_pre_rst", 14'h42, 32'h10);
    resetn = 1'b0;
    m_reset();
    peek("tval_rst", 14'h42, 32'hFFFF_FFFF);
    peek("crmd_rst", 14'h00, 32'h8);
    chk("has_int_rst", {31'b0, has_int}, 32'h0);
    step();
    step();
    peek("tval_in_rst", 14'h42, 32'hFFFF_FFFF);
    resetn = 1'b1;
    step();

    // periodic timer
    wr_csr(14'h04, 32'hFFFF_FFFF, 32'h800);
    wr_csr(14'h00, 32'h4, 32'h4);
    wr_csr(14'h41, 32'hFFFF_FFFF, 32'hB);
    peek("tval_load", 14'h42, 32'h8);
    repeat (8) step();
    peek("tval_zero", 14'h42, 32'h0);
    step();
    peek("tval_reload", 14'h42, 32'h8);
    peek("estat_fire", 14'h05, 32'h800);
    chk("has_int_tmr", {31'b0, has_int}, 32'h1);

    // one-shot with TICLR on the firing cycle
    wr_csr(14'h41, 32'hFFFF_FFFF, 32'h0);
    wr_csr(14'h44, 32'h1, 32'h1);
    peek("estat_clr", 14'h05, 32'h0);
    wr_csr(14'h41, 32'hFFFF_FFFF, 32'h9);
    repeat (8) step();
    wr_csr(14'h44, 32'h1, 32'h1);
    peek("estat_set_wins", 14'h05, 32'h800);
    peek("tval_wrap", 14'h42, 32'hFFFF_FFFF);
    repeat (3) step();
    peek("tval_hold", 14'h42, 32'hFFFF_FFFF);
    wr_csr(14'h44, 32'h1, 32'h1);
    peek("estat_clr2", 14'h05, 32'h0);
    chk("has_int_clr", {31'b0, has_int}, 32'h0);

    // exception entry and return
    wr_csr(14'h00, 32'h7, 32'h7);
    wr_csr(14'h30, 32'hFFFF_FFFF, 32'h55);
    wb_ex = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'h0;
    wb_pc = 32'h1C00_0100; wb_vaddr = 32'h1003;
    wr_csr(14'h30, 32'hFFFF_FFFF, 32'hDEAD);
    wb_ex = 1'b0;
    peek("era", 14'h06, 32'h1C00_0100);
    peek("badv", 14'h07, 32'h1003);
    peek("prmd", 14'h01, 32'h7);
    step();
    peek("crmd_ex", 14'h00, 32'h8);
    peek("save0_kept", 14'h30, 32'h55);
    chk("era_out", era_out, 32'h1C00_0100);
    ertn_flush = 1'b1;
    step();
    ertn_flush = 1'b0;
    peek("crmd_ertn", 14'h00, 32'hF);

    // SAVE masking and out-of-range index
    wr_csr(14'h30, 32'hFFFF_FFFF, 32'h1234_5678);
    wr_csr(14'h30, 32'h0000_FFFF, 32'hA5A5_A5A5);
    wr_csr(14'h31, 32'hFFFF_FFFF, 32'h1234_5678);
    wr_csr(14'h31, 32'h0000_FFFF, 32'hA5A5_A5A5);
    peek("save0", 14'h30, 32'h1234_A5A5);
    peek("save1", 14'h31, 32'h1234_A5A5);
    step();
    wr_csr(14'h32, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    peek("save2", 14'h32, 32'h0);

    // hardware interrupt sampling
    wr_csr(14'h04, 32'hFFFF_FFFF, 32'h404);
    peek("ecfg_b10", 14'h04, 32'h4);
    hw_int_in = 8'h01;
    peek("estat_pre", 14'h05, 32'h0009_0000);
    step();
    peek("estat_hw", 14'h05, 32'h0009_0004);
    chk("has_int_hw", {31'b0, has_int}, 32'h1);
    hw_int_in = 8'h00;
    step();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      resetn = ($urandom_range(0, 499) != 0);
      csr_re = ($urandom_range(0, 7) != 0);
      csr_num = addrs[$urandom_range(0, 14)];
      if ($urandom_range(0, 15) == 0) csr_num = 14'($urandom);
      csr_we = $urandom_range(0, 1) == 1;
      csr_wmask = $urandom_range(0, 1) == 1 ? 32'hFFFF_FFFF : $urandom;
      csr_wvalue = $urandom;
      if (csr_num == 14'h41) csr_wvalue = $urandom_range(0, 63);
      wb_ex = ($urandom_range(0, 9) == 0);
      ertn_flush = ($urandom_range(0, 9) == 0);
      wb_pc = $urandom;
      wb_vaddr = $urandom;
      wb_ecode = 6'($urandom_range(7, 10));
      wb_esubcode = 9'($urandom);
      hw_int_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      ipi_int_in = ($urandom_range(0, 7) == 0);
      if (!resetn) m_reset();
      step();
    end
    resetn = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
